// File: rtl/grid_image_locator_if.sv
// Pixel-side bundle of the grid image locator: raster counters and pixel enable in,
// tile address / ID / overlay flags out.
interface grid_image_locator_if #(
  parameter int CNTR_WIDTH_H       = 10,
  parameter int CNTR_WIDTH_V       = 10,
  parameter int ROM_ADDR_BUS_WIDTH = 17,
  parameter int ID_WIDTH           = 4
);
  logic                          pix_en;
  logic [CNTR_WIDTH_H-1:0]       CounterX;
  logic [CNTR_WIDTH_V-1:0]       CounterY;
  logic [ID_WIDTH-1:0]           sel_id;
  logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr;
  logic [ID_WIDTH-1:0]           ImageID;
  logic                          isImage;
  logic                          border;
  logic [23:0]                   black_white;

  modport master (
    output pix_en, CounterX, CounterY, sel_id,
    input  ROM_Addr, ImageID, isImage, border, black_white
  );

  modport slave (
    input  pix_en, CounterX, CounterY, sel_id,
    output ROM_Addr, ImageID, isImage, border, black_white
  );
endinterface

// File: rtl/grid_image_locator.sv
// Two-stage, multiplier-free locator of a COLS x ROWS tile grid on the VGA raster.
// Optional selected-tile border overlay is built when SEL_BORDER_EN is defined.
module grid_image_locator #(
  parameter int          CNTR_WIDTH_H       = 10,
  parameter int          CNTR_WIDTH_V       = 10,
  parameter int          ROM_ADDR_BUS_WIDTH = 17,
  parameter int          ID_WIDTH           = 4,
  parameter int          COLS               = 4,
  parameter int          ROWS               = 3,
  parameter int          TILE_W             = 100,
  parameter int          TILE_H             = 100,
  parameter int          PITCH_X            = 128,
  parameter int          PITCH_Y            = 128,
  parameter int          ORIGIN_X           = 308,
  parameter int          ORIGIN_Y           = 20,
  parameter logic [23:0] BORDER_RGB         = 24'hFF0000
) (
  input logic                clk,
  input logic                rst_n,
  grid_image_locator_if.slave bus
);

  typedef logic [ROM_ADDR_BUS_WIDTH-1:0] addr_t;
  typedef logic [CNTR_WIDTH_H-1:0]       hcnt_t;
  typedef logic [CNTR_WIDTH_V-1:0]       vcnt_t;
  typedef logic [ID_WIDTH-1:0]           id_t;

  localparam addr_t TILE_SZ_A = addr_t'(TILE_W * TILE_H);
  localparam addr_t ROW_SZ_A  = addr_t'(COLS * TILE_W * TILE_H);
  localparam addr_t TILE_W_A  = addr_t'(TILE_W);
  localparam hcnt_t X_ORG     = hcnt_t'(ORIGIN_X);
  localparam hcnt_t X_TEND    = hcnt_t'(TILE_W - 1);
  localparam hcnt_t X_GEND    = hcnt_t'(PITCH_X - TILE_W);
  localparam vcnt_t Y_ORG     = vcnt_t'(ORIGIN_Y);
  localparam vcnt_t Y_TEND    = vcnt_t'(TILE_H - 1);
  localparam vcnt_t Y_GEND    = vcnt_t'(PITCH_Y - TILE_H);
  localparam id_t   ID_COLS   = id_t'(COLS);
  localparam id_t   LAST_COL  = id_t'(COLS - 1);
  localparam id_t   LAST_ROW  = id_t'(ROWS - 1);

  localparam logic [2:0] WAIT_FRAME = 3'd0;
  localparam logic [2:0] H_PRE      = 3'd1;
  localparam logic [2:0] H_TILE     = 3'd2;
  localparam logic [2:0] H_GAP      = 3'd3;
  localparam logic [2:0] H_DONE     = 3'd4;
  localparam logic [2:0] V_PRE      = 3'd1;
  localparam logic [2:0] V_TILE     = 3'd2;
  localparam logic [2:0] V_GAP      = 3'd3;
  localparam logic [2:0] V_DONE     = 3'd4;

  logic [2:0] h_st_p1, v_st_p1, h_st_nxt, v_st_nxt, h_cur;
  hcnt_t      hcnt_p1, hcnt_nxt;
  vcnt_t      vcnt_p1, vcnt_nxt;
  id_t        col_p1, col_nxt, row_p1, row_nxt;
  id_t        id_p1, id_nxt, row_id_p1, row_id_nxt;
  addr_t      tile_base_p1, tile_base_nxt, row_base_p1, row_base_nxt;
  addr_t      row_tb_p1, row_tb_nxt;
  logic       frame_sync, line_start, in_tile_p1;

  addr_t      rom_addr_p2;
  id_t        id_p2;
  logic       img_p2;

  assign frame_sync = (bus.CounterX == '0) && (bus.CounterY == '0);
  assign line_start = (bus.CounterX == '0);

  always_comb begin
    v_st_nxt     = v_st_p1;
    vcnt_nxt     = vcnt_p1;
    row_nxt      = row_p1;
    row_id_nxt   = row_id_p1;
    row_tb_nxt   = row_tb_p1;
    row_base_nxt = row_base_p1;
    h_st_nxt     = h_st_p1;
    hcnt_nxt     = hcnt_p1;
    col_nxt      = col_p1;
    id_nxt       = id_p1;
    tile_base_nxt = tile_base_p1;

    // Vertical tracking only moves on the first pixel of a line.
    if (frame_sync) begin
      v_st_nxt     = V_PRE;
      vcnt_nxt     = '0;
      row_nxt      = '0;
      row_id_nxt   = '0;
      row_tb_nxt   = '0;
      row_base_nxt = '0;
    end else if (line_start) begin
      case (v_st_p1)
        V_PRE: begin
          if (bus.CounterY == Y_ORG) begin
            v_st_nxt     = V_TILE;
            vcnt_nxt     = '0;
            row_base_nxt = '0;
          end
        end
        V_TILE: begin
          if (vcnt_p1 == Y_TEND) begin
            v_st_nxt = V_GAP;
            vcnt_nxt = vcnt_t'(1);
          end else begin
            vcnt_nxt     = vcnt_p1 + 1'b1;
            row_base_nxt = row_base_p1 + TILE_W_A;
          end
        end
        V_GAP: begin
          if (vcnt_p1 == Y_GEND) begin
            if (row_p1 == LAST_ROW) begin
              v_st_nxt = V_DONE;
            end else begin
              v_st_nxt     = V_TILE;
              vcnt_nxt     = '0;
              row_base_nxt = '0;
              row_nxt      = row_p1 + 1'b1;
              row_id_nxt   = row_id_p1 + ID_COLS;
              row_tb_nxt   = row_tb_p1 + ROW_SZ_A;
            end
          end else begin
            vcnt_nxt = vcnt_p1 + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Horizontal tracking restarts every line once a frame has been seen.
    h_cur = (line_start && (v_st_nxt != WAIT_FRAME)) ? H_PRE : h_st_p1;
    h_st_nxt = h_cur;
    case (h_cur)
      H_PRE: begin
        if (bus.CounterX == X_ORG) begin
          h_st_nxt      = H_TILE;
          hcnt_nxt      = '0;
          col_nxt       = '0;
          id_nxt        = row_id_nxt;
          tile_base_nxt = row_tb_nxt;
        end
      end
      H_TILE: begin
        if (hcnt_p1 == X_TEND) begin
          h_st_nxt = H_GAP;
          hcnt_nxt = hcnt_t'(1);
        end else begin
          hcnt_nxt = hcnt_p1 + 1'b1;
        end
      end
      H_GAP: begin
        if (hcnt_p1 == X_GEND) begin
          if (col_p1 == LAST_COL) begin
            h_st_nxt = H_DONE;
          end else begin
            h_st_nxt      = H_TILE;
            hcnt_nxt      = '0;
            col_nxt       = col_p1 + 1'b1;
            id_nxt        = id_p1 + 1'b1;
            tile_base_nxt = tile_base_p1 + TILE_SZ_A;
          end
        end else begin
          hcnt_nxt = hcnt_p1 + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage 1: FSM state, offsets and bases for the accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_st_p1      <= WAIT_FRAME;
      v_st_p1      <= WAIT_FRAME;
      hcnt_p1      <= '0;
      vcnt_p1      <= '0;
      col_p1       <= '0;
      row_p1       <= '0;
      id_p1        <= '0;
      row_id_p1    <= '0;
      row_tb_p1    <= '0;
      row_base_p1  <= '0;
      tile_base_p1 <= '0;
    end else if (bus.pix_en) begin
      h_st_p1      <= h_st_nxt;
      v_st_p1      <= v_st_nxt;
      hcnt_p1      <= hcnt_nxt;
      vcnt_p1      <= vcnt_nxt;
      col_p1       <= col_nxt;
      row_p1       <= row_nxt;
      id_p1        <= id_nxt;
      row_id_p1    <= row_id_nxt;
      row_tb_p1    <= row_tb_nxt;
      row_base_p1  <= row_base_nxt;
      tile_base_p1 <= tile_base_nxt;
    end
  end

  assign in_tile_p1 = (h_st_p1 == H_TILE) && (v_st_p1 == V_TILE);

  // Stage 2: address sum and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_p2 <= '0;
      id_p2       <= '0;
      img_p2      <= 1'b0;
    end else if (bus.pix_en) begin
      rom_addr_p2 <= in_tile_p1 ? (tile_base_p1 + row_base_p1 + addr_t'(hcnt_p1)) : '0;
      id_p2       <= in_tile_p1 ? id_p1 : '0;
      img_p2      <= in_tile_p1;
    end
  end

  assign bus.ROM_Addr = rom_addr_p2;
  assign bus.ImageID  = id_p2;
  assign bus.isImage  = img_p2;

`ifdef SEL_BORDER_EN
  id_t  sel_p1;
  logic border_p2, edge_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_p1 <= '0;
    end else if (bus.pix_en) begin
      sel_p1 <= bus.sel_id;
    end
  end

  assign edge_p1 = (hcnt_p1 == '0) || (hcnt_p1 == X_TEND) ||
                   (vcnt_p1 == '0) || (vcnt_p1 == Y_TEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      border_p2 <= 1'b0;
    end else if (bus.pix_en) begin
      border_p2 <= in_tile_p1 && (id_p1 == sel_p1) && edge_p1;
    end
  end

  assign bus.border      = border_p2;
  assign bus.black_white = border_p2 ? BORDER_RGB : 24'h0;
`else
  logic unused_sel;
  assign unused_sel      = ^{bus.sel_id, BORDER_RGB};
  assign bus.border      = 1'b0;
  assign bus.black_white = 24'h0;
`endif

endmodule

// File: tb/tb_grid_image_locator.sv
// Bench for grid_image_locator: directed raster scenarios plus randomized frames with stalls,
// resets and sel_id, all checked against a coordinate-arithmetic model of the tile grid.
module tb_grid_image_locator;
  localparam int OX = 308, OY = 20, PX = 128, PY = 128;
  localparam int TW = 100, TH = 100, NC = 4, NR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grid_image_locator_if bus ();
  grid_image_locator dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        img;
    logic [3:0]  id;
    logic [16:0] addr;
    logic        bord;
    logic [23:0] bw;
  } exp_t;

  typedef struct packed {
    int x; int y; int img; int id; int addr; int bord;
  } spot_t;

  int    total = 0, bad = 0;
  exp_t  e1, e2;
  bit    s1, s2, synced;
  int    x1, y1, x2, y2;
  int    sel;
  spot_t spots[$];

  function automatic exp_t ref_pix(input int x, input int y, input int s);
    exp_t r;
    int dx, dy, c, rw, ox, oy;
    r  = '0;
    dx = x - OX;
    dy = y - OY;
    if (dx >= 0 && dy >= 0) begin
      c  = dx / PX;  ox = dx % PX;
      rw = dy / PY;  oy = dy % PY;
      if (c < NC && rw < NR && ox < TW && oy < TH) begin
        r.img  = 1'b1;
        r.id   = 4'(rw * NC + c);
        r.addr = 17'((rw * NC + c) * TW * TH + oy * TW + ox);
`ifdef SEL_BORDER_EN
        if (s == rw * NC + c && (ox == 0 || ox == TW - 1 || oy == 0 || oy == TH - 1)) begin
          r.bord = 1'b1;
          r.bw   = 24'hFF0000;
        end
`endif
      end
    end
    if (s < 0) r = '0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (pixel %0d,%0d)", tag, got, exp, x2, y2);
    end
  endtask

  task automatic step(input int x, input int y, input bit en, input bit rn);
    bus.pix_en   = en;
    bus.CounterX = 10'(x);
    bus.CounterY = 10'(y);
    bus.sel_id   = 4'(sel);
    rst_n        = rn;
    @(posedge clk);
    if (!rn) begin
      synced = 1'b0; e1 = '0; e2 = '0; s1 = 1'b0; s2 = 1'b0;
      x1 = -1; y1 = -1; x2 = -1; y2 = -1;
    end else if (en) begin
      e2 = e1; s2 = s1; x2 = x1; y2 = y1;
      if (x == 0 && y == 0) synced = 1'b1;
      e1 = synced ? ref_pix(x, y, sel) : '0;
      s1 = synced; x1 = x; y1 = y;
    end
    #1;
    check("rom_addr", 32'(bus.ROM_Addr), 32'(e2.addr));
    check("image_id", 32'(bus.ImageID), 32'(e2.id));
    check("is_image", 32'(bus.isImage), 32'(e2.img));
    check("border", 32'(bus.border), 32'(e2.bord));
    check("black_white", 32'(bus.black_white), 32'(e2.bw));
    if (s2) begin
      foreach (spots[i]) begin
        if (spots[i].x == x2 && spots[i].y == y2) begin
          check("spot_img", 32'(bus.isImage), 32'(spots[i].img));
          check("spot_id", 32'(bus.ImageID), 32'(spots[i].id));
          check("spot_addr", 32'(bus.ROM_Addr), 32'(spots[i].addr));
`ifdef SEL_BORDER_EN
          check("spot_border", 32'(bus.border), 32'(spots[i].bord));
`else
          check("spot_border", 32'(bus.border), 32'(0));
`endif
        end
      end
    end
  endtask

  task automatic pix(input int x, input int y);
    if ($urandom_range(0, 7) == 0)
      repeat ($urandom_range(1, 3)) step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b1);
    step(x, y, 1'b1, 1'b1);
  endtask

  task automatic scan(input int y, input int xs, input int xe);
    step(0, y, 1'b1, 1'b1);
    for (int x = xs; x <= xe; x++) step(x, y, 1'b1, 1'b1);
  endtask

  initial begin
    spots.push_back('{308, 20, 1, 0, 0, 0});
    spots.push_back('{407, 20, 1, 0, 99, 0});
    spots.push_back('{408, 20, 0, 0, 0, 0});
    spots.push_back('{436, 20, 1, 1, 10000, 0});
    spots.push_back('{350, 50, 1, 0, 3042, 0});
    spots.push_back('{436, 148, 1, 5, 50000, 1});
    spots.push_back('{437, 149, 1, 5, 50101, 0});
    spots.push_back('{308, 148, 1, 4, 40000, 0});
    spots.push_back('{535, 247, 1, 5, 59999, 1});
    spots.push_back('{791, 375, 1, 11, 119999, 0});
    spots.push_back('{792, 375, 0, 0, 0, 0});
    spots.push_back('{308, 376, 0, 0, 0, 0});

    sel = 5;
    @(negedge clk);
    repeat (3) step(OX, OY, 1'b1, 1'b0);
    scan(20, 300, 320);

    // Frame 1: directed coordinates, with a stall in the middle of tile 0.
    step(0, 0, 1'b1, 1'b1);
    for (int y = 1; y <= 376; y++) begin
      if (y == 20 || y == 148 || y == 149 || y == 247 || y == 375) begin
        scan(y, 300, 800);
      end else if (y == 50) begin
        scan(y, 300, 350);
        repeat (5) step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 1'b1);
        for (int x = 351; x <= 360; x++) step(x, y, 1'b1, 1'b1);
      end else if (y == 376) begin
        scan(y, 300, 320);
      end else begin
        step(0, y, 1'b1, 1'b1);
      end
    end

    // Frame 2: reset mid-tile, outputs stay low until the next frame sync.
    step(0, 0, 1'b1, 1'b1);
    for (int y = 1; y < 200; y++) step(0, y, 1'b1, 1'b1);
    scan(200, 300, 499);
    step(500, 200, 1'b1, 1'b0);
    for (int x = 501; x <= 520; x++) step(x, 200, 1'b1, 1'b1);
    for (int y = 201; y <= 210; y++) begin
      if (y == 210) scan(y, 300, 500);
      else step(0, y, 1'b1, 1'b1);
    end
    step(0, 0, 1'b1, 1'b1);
    for (int y = 1; y <= 20; y++) begin
      if (y == 20) scan(y, 300, 420);
      else step(0, y, 1'b1, 1'b1);
    end

    // Randomized frames: sparse full lines, stalls, resets and sel_id values.
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 420; y++) begin
        sel = int'($urandom_range(0, 15));
        if (y > 0 && $urandom_range(0, 199) == 0)
          step(int'($urandom_range(0, 1023)), y, 1'b1, 1'b0);
        pix(0, y);
        if ($urandom_range(0, 31) == 0 || (f == 0 && (y == 148 || y == 375))) begin
          int xs, xe;
          xs = 290 + int'($urandom_range(0, 18));
          xe = 790 + int'($urandom_range(0, 39));
          for (int x = xs; x <= xe; x++) pix(x, y);
        end
      end
    end
    step(0, 1, 1'b1, 1'b1);
    step(0, 2, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
